// File: rtl/mem_access_ctrl.sv
// Request sequencer for the 8x8 bit-level memory: valid/ready requests in, held select/op/adr/data out.
// Optional write-verify read-back is compiled in with `define MEMCTRL_WRITE_VERIFY_EN.
module mem_access_ctrl #(
  parameter int HOLD_CYCLES = 2,
  parameter int ADDR_W      = 3,
  parameter int DATA_W      = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              mem_select,
  output logic              mem_op,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              verify_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_VGAP,
    S_VERIFY
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(HOLD_CYCLES - 1);

  state_t              r_state;
  logic [3:0]          r_cnt;
  logic                r_we;
  logic                r_req_ready;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_data;
  logic                r_sel;
  logic                r_op;
  logic [ADDR_W-1:0]   r_adr;
  logic [DATA_W-1:0]   r_din;
`ifdef MEMCTRL_WRITE_VERIFY_EN
  logic                r_verify_err;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_sel       <= 1'b0;
      r_op        <= 1'b0;
      r_adr       <= '0;
      r_din       <= '0;
`ifdef MEMCTRL_WRITE_VERIFY_EN
      r_verify_err <= 1'b0;
`endif
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_sel <= 1'b0;
          r_op  <= 1'b0;
          // Ready is only ever high in IDLE, so every accept is followed by a full access.
          if (req_valid && r_req_ready) begin
            r_we        <= req_we;
            r_adr       <= req_addr;
            if (req_we) begin
              r_din <= req_wdata;
            end
            r_cnt       <= CNT_LOAD;
            r_sel       <= 1'b1;
            r_op        <= req_we;
            r_req_ready <= 1'b0;
            r_state     <= S_ACCESS;
          end else begin
            r_req_ready <= 1'b1;
          end
        end

        S_ACCESS: begin
          if (r_cnt == 4'd0) begin
            r_sel <= 1'b0;
            r_op  <= 1'b0;
            if (!r_we) begin
              // mem_dout is trusted only in the last held cycle of a read.
              r_rsp_data  <= mem_dout;
              r_rsp_valid <= 1'b1;
            end
`ifdef MEMCTRL_WRITE_VERIFY_EN
            if (r_we) begin
              r_state <= S_VGAP;
            end else begin
              r_req_ready <= 1'b1;
              r_state     <= S_IDLE;
            end
`else
            r_req_ready <= 1'b1;
            r_state     <= S_IDLE;
`endif
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end

`ifdef MEMCTRL_WRITE_VERIFY_EN
        S_VGAP: begin
          r_sel   <= 1'b1;
          r_op    <= 1'b0;
          r_cnt   <= CNT_LOAD;
          r_state <= S_VERIFY;
        end

        S_VERIFY: begin
          if (r_cnt == 4'd0) begin
            // r_din still holds the data just written; reads never touch it.
            if (mem_dout != r_din) begin
              r_verify_err <= 1'b1;
            end
            r_sel       <= 1'b0;
            r_op        <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
`endif

        default: begin
          r_sel       <= 1'b0;
          r_op        <= 1'b0;
          r_req_ready <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_data   = r_rsp_data;
  assign mem_select = r_sel;
  assign mem_op     = r_op;
  assign mem_adr    = r_adr;
  assign mem_din    = r_din;
`ifdef MEMCTRL_WRITE_VERIFY_EN
  assign verify_err = r_verify_err;
`else
  assign verify_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: random and directed requests against a queue/array reference model.
`timescale 1ns/1ps
module tb_mem_access_ctrl;
  localparam int H = 2;
`ifdef MEMCTRL_WRITE_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_we = 1'b0;
  logic [2:0] req_addr = 3'd0;
  logic [7:0] req_wdata = 8'h00;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       mem_select;
  logic       mem_op;
  logic [2:0] mem_adr;
  logic [7:0] mem_din;
  logic [7:0] mem_dout;
  logic       verify_err;

  mem_access_ctrl #(.HOLD_CYCLES(H), .ADDR_W(3), .DATA_W(8)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .mem_select(mem_select), .mem_op(mem_op), .mem_adr(mem_adr),
    .mem_din(mem_din), .mem_dout(mem_dout), .verify_err(verify_err)
  );

  always #5 i_clk = ~i_clk;

  // Behavioural 8x8 memory; force_b0 models a stuck-at-0 on output bit 0.
  logic [7:0] mem_arr [8] = '{default: 8'h00};
  bit         force_b0 = 1'b0;
  always @(posedge i_clk) if (mem_select && mem_op) mem_arr[mem_adr] <= mem_din;
  assign mem_dout = (mem_select && !mem_op) ? (mem_arr[mem_adr] & (force_b0 ? 8'hFE : 8'hFF)) : 8'h00;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct { logic [7:0] data; int due; } rsp_t;
  typedef struct { logic sel; logic op; logic [2:0] adr; logic [7:0] din; } line_t;
  rsp_t       exp_q[$];
  int         rd_idx = 0;
  line_t      line_a[int];
  logic [7:0] ref_mem [8] = '{default: 8'h00};
  logic [7:0] last_din = 8'h00;
  int         earliest = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endfunction

  // Reference model: what each accepted request should do to the memory lines and the response stream.
  task automatic model_accept(input int acc, input bit we, input logic [2:0] addr, input logic [7:0] data);
    logic [7:0] d;
    d = we ? data : last_din;
    for (int k = 0; k < H; k++) line_a[acc + k] = '{1'b1, we, addr, d};
    line_a[acc + H] = '{1'b0, 1'b0, addr, d};
    if (VERIFY && we) begin
      for (int k = 0; k < H; k++) line_a[acc + H + 1 + k] = '{1'b1, 1'b0, addr, d};
      line_a[acc + 2*H + 1] = '{1'b0, 1'b0, addr, d};
      earliest = acc + 2*H + 2;
    end else begin
      earliest = acc + H + 1;
    end
    last_din = d;
    if (we) ref_mem[addr] = data;
    else    exp_q.push_back('{ref_mem[addr], acc + H});
  endtask

  always @(negedge i_clk) begin
    if (rd_idx < exp_q.size() && exp_q[rd_idx].due < cyc) begin
      n_chk++; n_fail++;
      $display("FAIL rsp_missing at cycle %0d: no rsp_valid, expected one at cycle %0d", cyc, exp_q[rd_idx].due);
      rd_idx <= rd_idx + 1;
    end else if (rsp_valid) begin
      if (rd_idx >= exp_q.size()) begin
        n_chk++; n_fail++;
        $display("FAIL rsp_unexpected at cycle %0d: got rsp_valid=1 data 0x%0h, expected none", cyc, rsp_data);
      end else begin
        chk("rsp_data", 32'(rsp_data), 32'(exp_q[rd_idx].data));
        chk("rsp_cycle", 32'(cyc), 32'(exp_q[rd_idx].due));
        rd_idx <= rd_idx + 1;
      end
    end
    if (line_a.exists(cyc)) begin
      chk("mem_select", 32'(mem_select), 32'(line_a[cyc].sel));
      chk("mem_op", 32'(mem_op), 32'(line_a[cyc].op));
      chk("mem_adr", 32'(mem_adr), 32'(line_a[cyc].adr));
      chk("mem_din", 32'(mem_din), 32'(line_a[cyc].din));
    end
  end

  task automatic do_req(input bit we, input logic [2:0] addr, input logic [7:0] data);
    int start;
    int waited;
    int exp_acc;
    @(negedge i_clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = data;
    start = cyc; waited = 0;
    while (req_ready !== 1'b1 && waited < 64) begin
      @(negedge i_clk);
      waited++;
    end
    if (waited >= 64) begin
      n_chk++; n_fail++;
      $display("FAIL accept_timeout at cycle %0d: req_ready=%b, expected 1 within 64 cycles", cyc, req_ready);
      req_valid = 1'b0;
      return;
    end
    exp_acc = (earliest > start + 1) ? earliest : start + 1;
    chk("accept_cycle", 32'(cyc + 1), 32'(exp_acc));
    model_accept(cyc + 1, we, addr, data);
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle(input int n);
    @(negedge i_clk);
    req_valid = 1'b0;
    repeat (n) @(negedge i_clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
    chk({tag, "_mem_select"}, 32'(mem_select), 32'd0);
    chk({tag, "_mem_op"}, 32'(mem_op), 32'd0);
    chk({tag, "_mem_adr"}, 32'(mem_adr), 32'd0);
    chk({tag, "_mem_din"}, 32'(mem_din), 32'd0);
    chk({tag, "_verify_err"}, 32'(verify_err), 32'd0);
  endtask

  task automatic summary();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
  endtask

  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog at cycle %0d: simulation time limit reached, expected $finish earlier", cyc);
    summary();
    $fatal(1, "time limit");
  end

  initial begin
    int waited;
    logic [7:0] wd [5] = '{8'h4D, 8'h48, 8'h45, 8'h52, 8'h4C};
    logic [2:0] wa [5] = '{3'd4, 3'd7, 3'd6, 3'd0, 3'd1};

    // Reset held 3 cycles with a pending request.
    i_rst = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_addr = 3'd5; req_wdata = 8'hFF;
    repeat (3) begin
      @(negedge i_clk);
      chk_all_zero("reset");
    end
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("post_reset_ready", 32'(req_ready), 32'd1);
    chk("post_reset_select", 32'(mem_select), 32'd0);
    req_valid = 1'b0;
    earliest = cyc + 1;
    @(negedge i_clk);
    chk("post_reset_no_access", 32'(mem_select), 32'd0);

    // Single write, then the five back-to-back writes and five back-to-back reads.
    do_req(1'b1, 3'd4, 8'h4D);
    idle(3);
    for (int i = 0; i < 5; i++) do_req(1'b1, wa[i], wd[i]);
    for (int i = 0; i < 5; i++) do_req(1'b0, wa[i], 8'h00);
    idle(4);
    chk("ref_addr7", 32'(ref_mem[7]), 32'h48);

    // Stall: request held through ACCESS must wait for IDLE.
    do_req(1'b0, 3'd6, 8'h00);
    @(negedge i_clk);
    chk("stall_ready_low", 32'(req_ready), 32'd0);
    do_req(1'b0, 3'd0, 8'h00);
    idle(4);

    // Reset in the first ACCESS cycle of a read of addr 7; no response may follow.
    @(negedge i_clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 3'd7;
    waited = 0;
    while (req_ready !== 1'b1 && waited < 64) begin
      @(negedge i_clk);
      waited++;
    end
    @(posedge i_clk);
    #1;
    req_valid = 1'b0;
    i_rst = 1'b1;
    @(negedge i_clk);
    chk("abort_access_started", 32'(mem_select), 32'd1);
    @(negedge i_clk);
    chk("abort_select", 32'(mem_select), 32'd0);
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    i_rst = 1'b0;
    last_din = 8'h00;
    @(negedge i_clk);
    chk("abort_ready", 32'(req_ready), 32'd1);
    earliest = cyc + 1;
    do_req(1'b0, 3'd7, 8'h00);
    idle(4);

    // Randomised traffic with random idle gaps.
    for (int i = 0; i < 60; i++) begin
      do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(2*H + 4);
    chk("verify_err_clean", 32'(verify_err), 32'd0);

`ifdef MEMCTRL_WRITE_VERIFY_EN
    force_b0 = 1'b1;
    do_req(1'b1, 3'd2, 8'hA5);
    idle(2*H + 3);
    force_b0 = 1'b0;
    chk("verify_err_set", 32'(verify_err), 32'd1);
    do_req(1'b1, 3'd3, 8'h3C);
    idle(2*H + 3);
    chk("verify_err_sticky", 32'(verify_err), 32'd1);
    do_req(1'b0, 3'd2, 8'h00);
    do_req(1'b0, 3'd3, 8'h00);
    idle(2*H + 3);
`endif

    idle(4);
    chk("rsp_drained", 32'(rd_idx), 32'(exp_q.size()));
    summary();
    $finish;
  end
endmodule
